// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined Hamming SEC-DED decoder with a valid/ready stream interface
// and saturating corrected/uncorrectable error counters.
module hamming_secded_decoder #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8,
    // Smallest P with 2^P >= DATA_W + P + 1; one refinement of the clog2 estimate is exact.
    localparam int unsigned P = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
    localparam int unsigned N = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_cw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_single,
    output logic              out_double,
    output logic [P-1:0]      out_pos,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic         s1_valid_q;
    logic [N-1:0] s1_cw_q;
    logic [P-1:0] s1_syn_q;
    logic         s1_par_q;

    logic         s2_adv;
    logic         s1_adv;
    logic         out_hs;

    logic [P-1:0]      in_syn;
    logic              in_par;
    logic [N-1:0]      fix_cw;
    logic              dec_single;
    logic              dec_double;
    logic [P-1:0]      dec_pos;
    logic [DATA_W-1:0] dec_data;
    int unsigned       di;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = !rst && s1_adv;
    assign out_hs   = out_valid && out_ready;

    // Syndrome is the XOR of the indices of every set Hamming position.
    always_comb begin
        in_syn = '0;
        for (int k = 1; k < N; k++) begin
            if (in_cw[k]) begin
                in_syn = in_syn ^ k[P-1:0];
            end
        end
    end

    assign in_par = ^in_cw;

    always_comb begin
        fix_cw     = s1_cw_q;
        dec_single = 1'b0;
        dec_double = 1'b0;
        dec_pos    = '0;
        if (s1_par_q) begin
            if (s1_syn_q == '0) begin
                dec_single = 1'b1;
            end else if (32'(s1_syn_q) < N) begin
                dec_single       = 1'b1;
                dec_pos          = s1_syn_q;
                fix_cw[s1_syn_q] = ~s1_cw_q[s1_syn_q];
            end else begin
                dec_double = 1'b1;
            end
        end else if (s1_syn_q != '0) begin
            dec_double = 1'b1;
        end
    end

    // Data bits live at the non-power-of-two positions, LSB first.
    always_comb begin
        dec_data = '0;
        di       = 0;
        for (int k = 1; k < N; k++) begin
            if ((k & (k - 1)) != 0) begin
                dec_data[di] = fix_cw[k];
                di           = di + 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_cw_q    <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_single <= 1'b0;
            out_double <= 1'b0;
            out_pos    <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_cw_q  <= in_cw;
                    s1_syn_q <= in_syn;
                    s1_par_q <= in_par;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data   <= dec_data;
                    out_single <= dec_single;
                    out_double <= dec_double;
                    out_pos    <= dec_pos;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_hs) begin
            if (out_single && corr_cnt != CntMax) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
            if (out_double && uncorr_cnt != CntMax) begin
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: directed vector table, backpressure, counter saturation,
// mid-stream reset, and a random stream scored against an error-injection model.
module tb_hamming_secded_decoder;

    localparam int unsigned DW   = 4;
    localparam int unsigned CW   = 3;
    localparam int unsigned PW   = 3;
    localparam int unsigned NW   = 8;
    localparam int          CMAX = 7;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          single;
        logic          dbl;
        logic [PW-1:0] pos;
    } exp_t;

    typedef struct {
        logic [NW-1:0] cw;
        logic [DW-1:0] data;
        logic          single;
        logic          dbl;
        logic [PW-1:0] pos;
        int            corr;
        int            uncorr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NW-1:0] in_cw = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_single;
    logic          out_double;
    logic [PW-1:0] out_pos;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;

    int   checks = 0;
    int   errors = 0;
    int   m_corr = 0;
    int   m_uncorr = 0;
    int   delivered = 0;
    exp_t q[$];
    logic hold = 1'b0;
    exp_t held;
    logic acc;
    vec_t tbl[8];

    always #5 clk = ~clk;

    hamming_secded_decoder #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cw      (in_cw),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_single (out_single),
        .out_double (out_double),
        .out_pos    (out_pos),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    function automatic logic is_pow2(input int k);
        return (k & (k - 1)) == 0;
    endfunction

    // Build a valid codeword: data into non-power-of-two slots, then even parity per group.
    function automatic logic [NW-1:0] encode(input logic [DW-1:0] d);
        logic [NW-1:0] c;
        int            di;
        logic          p;
        c  = '0;
        di = 0;
        for (int k = 1; k < int'(NW); k++) begin
            if (!is_pow2(k)) begin
                c[k] = d[di];
                di++;
            end
        end
        for (int m = 0; m < int'(PW); m++) begin
            p = 1'b0;
            for (int k = 1; k < int'(NW); k++) begin
                if (((k >> m) & 1) == 1 && k != (1 << m)) p ^= c[k];
            end
            c[1 << m] = p;
        end
        c[0] = ^c[NW-1:1];
        return c;
    endfunction

    function automatic logic [DW-1:0] raw_data(input logic [NW-1:0] c);
        logic [DW-1:0] d;
        int            di;
        d  = '0;
        di = 0;
        for (int k = 1; k < int'(NW); k++) begin
            if (!is_pow2(k)) begin
                d[di] = c[k];
                di++;
            end
        end
        return d;
    endfunction

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.data   = v.data;
        e.single = v.single;
        e.dbl    = v.dbl;
        e.pos    = v.pos;
        return e;
    endfunction

    // One clock cycle: drive at the falling edge, then score outputs and handshakes.
    task automatic step(input logic iv, input logic [NW-1:0] cw, input exp_t e,
                        input logic ordy, input logic clr, output logic accepted);
        exp_t got;
        exp_t want;
        @(negedge clk);
        in_valid  = iv;
        in_cw     = cw;
        out_ready = ordy;
        cnt_clr   = clr;
        #1;
        chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
        chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
        got = {out_data, out_single, out_double, out_pos};
        if (hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_stable", 32'(got), 32'(held));
        end
        hold = out_valid && !out_ready;
        held = got;
        if (out_valid) chk("single_and_double", 32'(out_single & out_double), 32'd0);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                want = q.pop_front();
                chk("out_data", 32'(out_data), 32'(want.data));
                chk("out_single", 32'(out_single), 32'(want.single));
                chk("out_double", 32'(out_double), 32'(want.dbl));
                chk("out_pos", 32'(out_pos), 32'(want.pos));
                delivered++;
                if (want.single && m_corr < CMAX) m_corr++;
                if (want.dbl && m_uncorr < CMAX) m_uncorr++;
            end
        end
        if (clr) begin
            m_corr   = 0;
            m_uncorr = 0;
        end
        accepted = iv && in_ready;
        if (accepted) q.push_back(e);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_corr_cnt", 32'(corr_cnt), 32'd0);
        chk("rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        chk("rst_in_ready_after", 32'(in_ready), 32'd1);
        q.delete();
        m_corr   = 0;
        m_uncorr = 0;
        hold     = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NW-1:0] cw;
        logic [DW-1:0] d;
        exp_t          e;
        logic          pend;
        logic          saw_stall;
        int            n_err;
        int            j1;
        int            j2;
        int            base;
        vec_t          bp[3];

        tbl[0] = '{8'hAA, 4'b1011, 1'b0, 1'b0, 3'd0, 0, 0};
        tbl[1] = '{8'hEA, 4'b1011, 1'b1, 1'b0, 3'd6, 1, 0};
        tbl[2] = '{8'hAB, 4'b1011, 1'b1, 1'b0, 3'd0, 2, 0};
        tbl[3] = '{8'h8E, 4'b1001, 1'b0, 1'b1, 3'd0, 2, 1};
        tbl[4] = '{8'h00, 4'b0000, 1'b0, 1'b0, 3'd0, 2, 1};
        tbl[5] = '{8'hFF, 4'b1111, 1'b0, 1'b0, 3'd0, 2, 1};
        tbl[6] = '{8'h01, 4'b0000, 1'b1, 1'b0, 3'd0, 3, 1};
        tbl[7] = '{8'h03, 4'b0000, 1'b0, 1'b1, 3'd0, 3, 2};

        do_reset();
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_single", 32'(out_single), 32'd0);
        chk("rst_out_double", 32'(out_double), 32'd0);
        chk("rst_out_pos", 32'(out_pos), 32'd0);

        // Single words with a fixed two-cycle latency.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].cw, mk_exp(tbl[i]), 1'b1, 1'b0, acc);
            chk("tbl_accept", 32'(acc), 32'd1);
            idle(1);
            chk("tbl_latency_early", 32'(out_valid), 32'd0);
            idle(1);
            chk("tbl_latency_valid", 32'(out_valid), 32'd1);
            idle(1);
            chk("tbl_corr_cnt", 32'(corr_cnt), 32'(tbl[i].corr));
            chk("tbl_uncorr_cnt", 32'(uncorr_cnt), 32'(tbl[i].uncorr));
        end

        // Back-to-back stream with out_ready low for cycles 3..5.
        bp[0]     = tbl[0];
        bp[1]     = tbl[1];
        bp[2]     = tbl[3];
        base      = delivered;
        saw_stall = 1'b0;
        begin
            int idx = 0;
            for (int c = 0; c < 20; c++) begin
                if (idx < 3) step(1'b1, bp[idx].cw, mk_exp(bp[idx]), !(c >= 3 && c <= 5), 1'b0, acc);
                else step(1'b0, '0, '0, !(c >= 3 && c <= 5), 1'b0, acc);
                if (acc) idx++;
                if (!in_ready) saw_stall = 1'b1;
            end
        end
        chk("bp_in_ready_dropped", 32'(saw_stall), 32'd1);
        chk("bp_delivered", 32'(delivered - base), 32'd3);
        chk("bp_queue_empty", 32'(q.size()), 32'd0);

        // Saturation of corr_cnt at 7, then clear winning over a counted handshake.
        step(1'b0, '0, '0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 10; i++) step(1'b1, tbl[1].cw, mk_exp(tbl[1]), 1'b1, 1'b0, acc);
        idle(4);
        chk("sat_corr_cnt", 32'(corr_cnt), 32'd7);
        step(1'b1, tbl[1].cw, mk_exp(tbl[1]), 1'b1, 1'b0, acc);
        idle(1);
        step(1'b0, '0, '0, 1'b1, 1'b1, acc);
        chk("clr_hs_valid", 32'(out_valid), 32'd1);
        idle(1);
        chk("clr_priority_corr", 32'(corr_cnt), 32'd0);

        // Random stream with 0, 1 or 2 injected bit errors per word.
        step(1'b0, '0, '0, 1'b1, 1'b1, acc);
        pend = 1'b0;
        cw   = '0;
        e    = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend && $urandom_range(0, 9) < 7) begin
                d     = DW'($urandom);
                cw    = encode(d);
                n_err = $urandom_range(0, 2);
                j1    = $urandom_range(0, NW - 1);
                j2    = (j1 + $urandom_range(1, NW - 1)) % NW;
                if (n_err >= 1) cw[j1] = ~cw[j1];
                if (n_err == 2) cw[j2] = ~cw[j2];
                if (n_err == 0) e = {d, 1'b0, 1'b0, PW'(0)};
                else if (n_err == 1) e = {d, 1'b1, 1'b0, PW'(j1)};
                else e = {raw_data(cw), 1'b0, 1'b1, PW'(0)};
                pend = 1'b1;
            end
            step(pend, cw, e, $urandom_range(0, 9) < 7, 1'b0, acc);
            if (acc) pend = 1'b0;
        end
        for (int c = 0; c < 40 && q.size() > 0; c++) idle(1);
        chk("rand_drain", 32'(q.size()), 32'd0);

        // Reset with two words in flight: both must vanish.
        step(1'b1, tbl[1].cw, mk_exp(tbl[1]), 1'b0, 1'b0, acc);
        step(1'b1, tbl[3].cw, mk_exp(tbl[3]), 1'b0, 1'b0, acc);
        do_reset();
        idle(6);
        chk("post_rst_idle_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
